// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Arbiter for the single unified instruction/data memory port shared by the multicycle CPU
// and a DMA/IO requester: one access at a time, issue -> latency wait -> done pulse.
//
// state | meaning
// IDLE  | port free; requests sampled and the winner's we/addr/wdata latched at the edge
// ISSUE | one-cycle mem_en strobe for the latched access
// WAIT  | MEM_LAT-cycle latency countdown; read data captured on the last edge
// DONE  | one-cycle done pulse to the winner, then back to IDLE
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              Reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_grant,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_grant,
    output logic              dma_done,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W    = $clog2(MEM_LAT + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arbState_t;

    arbState_t           state;
    arbState_t           nextState;
    logic                dmaOwner;
    logic                accWe;
    logic [CNT_W-1:0]    waitCnt;
    logic [STARVE_W-1:0] starveCnt;
    logic                dmaStarved;
    logic                grantCpu;
    logic                grantDma;
    logic                waitLast;
    logic                acceptReq;

    // CPU has priority unless DMA has lost STARVE_MAX arbitrations in a row.
    assign dmaStarved = (starveCnt == STARVE_W'(STARVE_MAX));
    assign grantDma   = dma_req & (~cpu_req | dmaStarved);
    assign grantCpu   = cpu_req & ~grantDma;
    assign acceptReq  = (state == IDLE) & (grantCpu | grantDma);
    assign waitLast   = (waitCnt == CNT_W'(1));

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        cpu_done  = 1'b0;
        dma_done  = 1'b0;
        case (state)
            IDLE: begin
                if (grantCpu || grantDma) begin
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                nextState = WAIT;
                mem_en    = 1'b1;
                mem_we    = accWe;
                cpu_grant = ~dmaOwner;
                dma_grant = dmaOwner;
            end
            WAIT: begin
                if (waitLast) begin
                    nextState = DONE;
                end
                cpu_grant = ~dmaOwner;
                dma_grant = dmaOwner;
            end
            DONE: begin
                nextState = IDLE;
                cpu_grant = ~dmaOwner;
                dma_grant = dmaOwner;
                cpu_done  = ~dmaOwner;
                dma_done  = dmaOwner;
            end
            default: nextState = IDLE;
        endcase
    end

    assign cpu_stall = cpu_req & ~cpu_done;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            dmaOwner  <= 1'b0;
            accWe     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            waitCnt   <= '0;
            starveCnt <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            if (acceptReq) begin
                dmaOwner  <= grantDma;
                accWe     <= grantDma ? dma_we    : cpu_we;
                mem_addr  <= grantDma ? dma_addr  : cpu_addr;
                mem_wdata <= grantDma ? dma_wdata : cpu_wdata;
                if (grantDma) begin
                    starveCnt <= '0;
                end else if (dma_req && !dmaStarved) begin
                    starveCnt <= starveCnt + STARVE_W'(1);
                end
            end

            if (state == ISSUE) begin
                waitCnt <= CNT_W'(MEM_LAT);
            end else if (state == WAIT) begin
                waitCnt <= waitCnt - CNT_W'(1);
            end

            // Read data is only valid on the final latency edge; writes leave rdata untouched.
            if ((state == WAIT) && waitLast && !accWe) begin
                if (dmaOwner) begin
                    dma_rdata <= mem_rdata;
                end else begin
                    cpu_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: table of single accesses, scoreboard of expected completions,
// plus hand sequences for starvation, simultaneous requests, mid-access reset and MEM_LAT=3.
module tb_mem_port_arbiter;

    typedef struct {
        logic        isDma;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] expRdata;
    } vec_t;

    typedef struct {
        logic        isDma;
        logic        we;
        logic [15:0] rdata;
        int          cyc;
        int          lat;
    } sbEntry_t;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;

    logic        cpu_req, cpu_we, cpu_grant, cpu_done, cpu_stall;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_grant, dma_done;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic        cpuReq2, cpuGrant2, cpuDone2, cpuStall2;
    logic [15:0] cpuAddr2, cpuRdata2;
    logic        dmaGrant2, dmaDone2;
    logic [15:0] dmaRdata2;
    logic        memEn2, memWe2;
    logic [15:0] memAddr2, memWdata2, memRdata2;

    logic [15:0] memArr [0:255];
    logic [3:0]  rdCnt, rdCnt2;
    logic [7:0]  rdAddr, rdAddr2;

    sbEntry_t    sbQ[$];
    vec_t        vecs[9];
    int          nChecks = 0;
    int          nFail = 0;
    int          cycleCnt = 0;
    logic [15:0] expCpuRd, expDmaRd;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_grant(cpu_grant), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_grant(dma_grant), .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .STARVE_MAX(4)) dut2 (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpuReq2), .cpu_we(1'b0), .cpu_addr(cpuAddr2), .cpu_wdata(16'h0000),
        .cpu_grant(cpuGrant2), .cpu_done(cpuDone2), .cpu_rdata(cpuRdata2), .cpu_stall(cpuStall2),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(16'h0000), .dma_wdata(16'h0000),
        .dma_grant(dmaGrant2), .dma_done(dmaDone2), .dma_rdata(dmaRdata2),
        .mem_en(memEn2), .mem_we(memWe2), .mem_addr(memAddr2), .mem_wdata(memWdata2),
        .mem_rdata(memRdata2)
    );

    // Memory returns valid data for exactly one cycle, MEM_LAT cycles after the strobe.
    assign mem_rdata = (rdCnt == 4'd1)  ? memArr[rdAddr]  : 16'hDEAD;
    assign memRdata2 = (rdCnt2 == 4'd1) ? memArr[rdAddr2] : 16'hDEAD;

    task check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task runCycleCount();
        forever begin
            @(posedge CLK);
            cycleCnt++;
        end
    endtask

    task runMemory();
        forever begin
            @(posedge CLK);
            if (Reset) begin
                rdCnt  <= 4'd0;
                rdCnt2 <= 4'd0;
            end else begin
                if (mem_en && !mem_we) begin
                    rdCnt  <= 4'd1;
                    rdAddr <= mem_addr[7:0];
                end else if (rdCnt != 4'd0) begin
                    rdCnt <= rdCnt - 4'd1;
                end
                if (mem_en && mem_we) begin
                    memArr[mem_addr[7:0]] <= mem_wdata;
                end
                if (memEn2) begin
                    rdCnt2  <= 4'd3;
                    rdAddr2 <= memAddr2[7:0];
                end else if (rdCnt2 != 4'd0) begin
                    rdCnt2 <= rdCnt2 - 4'd1;
                end
            end
        end
    endtask

    task runMonitor();
        sbEntry_t e;
        forever begin
            @(negedge CLK);
            if (!Reset) begin
                check("one_grant", {31'd0, cpu_grant & dma_grant}, 32'd0);
                check("we_without_en", {31'd0, mem_we & ~mem_en}, 32'd0);
                check("cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req & ~cpu_done});
                if (cpu_done || dma_done) begin
                    if (sbQ.size() == 0) begin
                        check("unexpected_done", {30'd0, cpu_done, dma_done}, 32'd0);
                    end else begin
                        e = sbQ.pop_front();
                        check("done_side", {30'd0, cpu_done, dma_done}, e.isDma ? 32'd1 : 32'd2);
                        check("done_rdata", e.isDma ? {16'd0, dma_rdata} : {16'd0, cpu_rdata},
                              {16'd0, e.rdata});
                        if (e.lat >= 0) begin
                            check("done_latency", cycleCnt - e.cyc, e.lat);
                        end
                    end
                end
            end
        end
    endtask

    task setReq(input logic isDma, input logic val);
        if (isDma) dma_req = val;
        else       cpu_req = val;
    endtask

    task waitDone(input logic isDma, input string name);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge CLK);
            got = isDma ? dma_done : cpu_done;
        end
        check(name, {31'd0, got}, 32'd1);
    endtask

    task access(input vec_t v);
        logic got;
        int   enCnt;
        @(posedge CLK); #1;
        if (v.isDma) begin
            dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
        end else begin
            cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        setReq(v.isDma, 1'b1);
        sbQ.push_back('{v.isDma, v.we, v.expRdata, cycleCnt, 3});
        got = 1'b0;
        enCnt = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge CLK);
            if (mem_en) begin
                enCnt++;
                check("mem_addr", {16'd0, mem_addr}, {16'd0, v.addr});
                check("mem_we", {31'd0, mem_we}, {31'd0, v.we});
                check("issue_grant", {31'd0, v.isDma ? dma_grant : cpu_grant}, 32'd1);
                if (v.we) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, v.wdata});
            end
            got = v.isDma ? dma_done : cpu_done;
        end
        check("access_done", {31'd0, got}, 32'd1);
        check("mem_en_count", enCnt, 32'd1);
        @(posedge CLK); #1;
        setReq(v.isDma, 1'b0);
        if (!v.we) begin
            if (v.isDma) expDmaRd = v.expRdata;
            else         expCpuRd = v.expRdata;
        end
        check("cpu_rdata_held", {16'd0, cpu_rdata}, {16'd0, expCpuRd});
        check("dma_rdata_held", {16'd0, dma_rdata}, {16'd0, expDmaRd});
    endtask

    task checkResetOutputs(input string name);
        check(name, {25'd0, cpu_grant, cpu_done, dma_grant, dma_done, mem_en, mem_we, cpu_stall}, 32'd0);
        check({name, "_addr_wdata"}, {mem_addr, mem_wdata}, 32'd0);
        check({name, "_rdata"}, {cpu_rdata, dma_rdata}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int n;
        int doneCyc;
        int enCnt;
        logic got;

        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        cpuReq2 = 0; cpuAddr2 = 0;
        rdCnt = 0; rdCnt2 = 0; rdAddr = 0; rdAddr2 = 0;
        expCpuRd = 16'h0000;
        expDmaRd = 16'h0000;
        for (int i = 0; i < 256; i++) memArr[i] = 16'h5A00 | 16'(i);
        memArr[8'h10] = 16'hBEEF;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 16'h00FF, 16'h1234, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h1234};
        vecs[3] = '{1'b0, 1'b1, 16'h0020, 16'h5555, 16'hBEEF};
        vecs[4] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5555};
        vecs[5] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[6] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 16'h5A03};
        vecs[7] = '{1'b1, 1'b1, 16'h00FF, 16'hFFFF, 16'hBEEF};
        vecs[8] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'hFFFF};

        fork
            runCycleCount();
            runMemory();
            runMonitor();
        join_none

        repeat (2) @(negedge CLK);
        checkResetOutputs("reset_state");
        @(posedge CLK); #1;
        Reset = 1'b0;
        @(negedge CLK);
        checkResetOutputs("after_reset");

        for (int i = 0; i < 9; i++) begin
            access(vecs[i]);
        end

        // Both sides requesting back-to-back: four CPU wins, then DMA is forced through.
        @(posedge CLK); #1;
        cpu_we = 0; cpu_addr = 16'h0010;
        dma_we = 0; dma_addr = 16'h0003;
        cpu_req = 1; dma_req = 1;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) sbQ.push_back('{1'b1, 1'b0, 16'h5A03, cycleCnt, -1});
            else            sbQ.push_back('{1'b0, 1'b0, 16'hBEEF, cycleCnt, -1});
        end
        seen = 0;
        for (int c = 0; c < 200 && seen < 10; c++) begin
            @(negedge CLK);
            if (cpu_done || dma_done) seen++;
        end
        check("starve_done_count", seen, 32'd10);
        @(posedge CLK); #1;
        cpu_req = 0; dma_req = 0;
        expCpuRd = 16'hBEEF;
        expDmaRd = 16'h5A03;
        repeat (3) @(negedge CLK);
        check("starve_sb_empty", sbQ.size(), 32'd0);

        // Simultaneous requests with starve_cnt = 0: CPU first, DMA right after.
        @(posedge CLK); #1;
        cpu_addr = 16'h0020;
        dma_addr = 16'h00FF;
        cpu_req = 1; dma_req = 1;
        sbQ.push_back('{1'b0, 1'b0, 16'h5555, cycleCnt, 3});
        sbQ.push_back('{1'b1, 1'b0, 16'hFFFF, cycleCnt, 7});
        waitDone(1'b0, "simul_cpu_done");
        check("simul_starve_cnt", {29'd0, dut1.starveCnt}, 32'd1);
        @(posedge CLK); #1;
        cpu_req = 0;
        waitDone(1'b1, "simul_dma_done");
        @(posedge CLK); #1;
        dma_req = 0;
        expCpuRd = 16'h5555;
        expDmaRd = 16'hFFFF;
        check("simul_sb_empty", sbQ.size(), 32'd0);

        // Reset in the WAIT state of a CPU read: everything clears at once, no done.
        @(posedge CLK); #1;
        cpu_we = 0; cpu_addr = 16'h0010;
        cpu_req = 1;
        repeat (3) @(negedge CLK);
        check("pre_reset_grant", {31'd0, cpu_grant}, 32'd1);
        #1;
        Reset = 1'b1;
        cpu_req = 0;
        #1;
        checkResetOutputs("mid_access_reset");
        @(posedge CLK); #1;
        Reset = 1'b0;
        expCpuRd = 16'h0000;
        expDmaRd = 16'h0000;
        repeat (4) @(negedge CLK);
        access('{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF});

        // MEM_LAT = 3 instance: single strobe, done at N+5 with the late data.
        @(posedge CLK); #1;
        cpuAddr2 = 16'h0010;
        cpuReq2 = 1;
        n = cycleCnt;
        got = 1'b0;
        enCnt = 0;
        doneCyc = -1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge CLK);
            if (memEn2) begin
                enCnt++;
                check("lat3_mem_addr", {16'd0, memAddr2}, 32'h10);
            end
            check("lat3_stall", {31'd0, cpuStall2}, {31'd0, ~cpuDone2});
            if (cpuDone2) begin
                got = 1'b1;
                doneCyc = cycleCnt;
            end
        end
        check("lat3_done_seen", {31'd0, got}, 32'd1);
        check("lat3_latency", doneCyc - n, 32'd5);
        check("lat3_en_count", enCnt, 32'd1);
        check("lat3_rdata", {16'd0, cpuRdata2}, 32'hBEEF);
        check("lat3_dma_side_idle", {dmaRdata2, 13'd0, dmaGrant2, dmaDone2, memWe2}, 32'd0);
        @(posedge CLK); #1;
        cpuReq2 = 0;
        repeat (3) @(negedge CLK);
        check("lat3_released", {30'd0, cpuGrant2, cpuStall2}, 32'd0);
        check("final_sb_empty", sbQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
